// File: rtl/trdb_output_arbiter_if.sv
// Word-stream bundle of the trace debugger output arbiter: trace source,
// software-dump source and the merged stream towards the uDMA.
// The master modport is the arbiter's view; slave is the environment's view.
interface trdb_output_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] trace_word_i;
    logic            trace_valid_i;
    logic            trace_grant_o;
    logic [XLEN-1:0] sw_word_i;
    logic            sw_valid_i;
    logic [XLEN-1:0] word_o;
    logic            word_src_o;
    logic            word_valid_o;
    logic            word_ready_i;

    modport master (
        input  trace_word_i, trace_valid_i, sw_word_i, sw_valid_i, word_ready_i,
        output trace_grant_o, word_o, word_src_o, word_valid_o
    );

    modport slave (
        output trace_word_i, trace_valid_i, sw_word_i, sw_valid_i, word_ready_i,
        input  trace_grant_o, word_o, word_src_o, word_valid_o
    );
endinterface

// File: rtl/trdb_output_arbiter.sv
// trdb_output_arbiter: merges trace packet words and software-dump words into a
// single registered word stream. Trace normally wins; after MAX_BURST trace
// words with a dump waiting, the dump FIFO gets the next slot. An IDLE/RUN/DRAIN
// FSM sequences enable and empties the dump FIFO after tracing is switched off.
// Build macro TRDB_SW_HEADER_EN: each dump goes out as a header word
// {8'hFF, 8'h00, seq[15:0]} followed by its payload, never split by trace.
module trdb_output_arbiter #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned SW_FIFO_DEPTH = 4,
    parameter int unsigned MAX_BURST     = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  clr_i,
    trdb_output_arbiter_if.master bus,
    output logic                  busy_o,
    output logic [15:0]           sw_dropped_o
);
    localparam int unsigned PTR_W   = $clog2(SW_FIFO_DEPTH);
    localparam int unsigned CNT_W   = $clog2(SW_FIFO_DEPTH + 1);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]   FIFO_FULL = CNT_W'(SW_FIFO_DEPTH);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     fifo_mem_q [SW_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [15:0]         dropped_q, dropped_d;
    logic [XLEN-1:0]     word_q, word_d;
    logic                src_q, src_d;
    logic                valid_q, valid_d;

    logic                fifo_empty_s, fifo_full_s, can_load_s, trace_ok_s;
    logic                sw_force_s, take_trace_s, take_sw_s, pop_s;
    logic                push_req_s, push_s, drop_s;
    logic [XLEN-1:0]     sw_out_s;

`ifdef TRDB_SW_HEADER_EN
    logic                hdr_pend_q, hdr_pend_d;
    logic [15:0]         seq_q, seq_d;
`endif

    // Arbitration between trace and the dump FIFO at each output load opportunity.
    always_comb begin
        fifo_empty_s = (fifo_cnt_q == CNT_W'(0));
        fifo_full_s  = (fifo_cnt_q == FIFO_FULL);
        can_load_s   = !valid_q || bus.word_ready_i;
        // Dropping enable blocks the trace grant in the very cycle it is seen.
        trace_ok_s   = bus.trace_valid_i && (state_q == ST_RUN) && enable_i;
`ifdef TRDB_SW_HEADER_EN
        // A header already sent forces its payload next, so a dump is never split.
        sw_force_s   = !fifo_empty_s && (hdr_pend_q || (burst_q == BURST_LIM));
`else
        sw_force_s   = !fifo_empty_s && (burst_q == BURST_LIM);
`endif
        take_trace_s = can_load_s && trace_ok_s && !sw_force_s;
        take_sw_s    = can_load_s && !fifo_empty_s && !take_trace_s;
`ifdef TRDB_SW_HEADER_EN
        pop_s        = take_sw_s && hdr_pend_q;
        sw_out_s     = hdr_pend_q ? fifo_mem_q[rd_ptr_q] : XLEN'({8'hFF, 8'h00, seq_q});
`else
        pop_s        = take_sw_s;
        sw_out_s     = fifo_mem_q[rd_ptr_q];
`endif
        // In IDLE a pulse only counts if enable is already up.
        push_req_s   = bus.sw_valid_i && ((state_q != ST_IDLE) || enable_i);
        push_s       = push_req_s && (!fifo_full_s || pop_s);
        drop_s       = push_req_s && fifo_full_s && !pop_s;
    end

    // FIFO occupancy next value.
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Output register next value: load when free or accepted, otherwise hold.
    always_comb begin
        word_d  = word_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (take_trace_s) begin
            word_d  = bus.trace_word_i;
            src_d   = 1'b0;
            valid_d = 1'b1;
        end else if (take_sw_s) begin
            word_d  = sw_out_s;
            src_d   = 1'b1;
            valid_d = 1'b1;
        end else if (can_load_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Burst counter: trace words taken back-to-back while a dump waits.
    always_comb begin
        burst_d = burst_q;
        if (pop_s) begin
            burst_d = BURST_W'(0);
        end else if (take_trace_s && fifo_empty_s) begin
            burst_d = BURST_W'(0);
        end else if (take_trace_s && (burst_q != BURST_LIM)) begin
            burst_d = burst_q + BURST_W'(1);
        end else begin
            burst_d = burst_q;
        end
    end

    // Saturating drop counter; a drop coinciding with clear counts as one.
    always_comb begin
        dropped_d = dropped_q;
        if (clr_i) begin
            dropped_d = drop_s ? 16'd1 : 16'd0;
        end else if (drop_s && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // FSM next state: DRAIN leaves once the FIFO is empty and the last word goes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RUN;
                else          state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_DRAIN;
                else           state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (enable_i)                                             state_d = ST_RUN;
                else if (fifo_empty_s && (!valid_q || bus.word_ready_i)) state_d = ST_IDLE;
                else                                                      state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, output register and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            word_q    <= {XLEN{1'b0}};
            src_q     <= 1'b0;
            valid_q   <= 1'b0;
            burst_q   <= BURST_W'(0);
            dropped_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            src_q     <= src_d;
            valid_q   <= valid_d;
            burst_q   <= burst_d;
            dropped_q <= dropped_d;
        end
    end

    // Dump FIFO storage and pointers; pointers wrap because depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(SW_FIFO_DEPTH); i++) begin
                fifo_mem_q[i] <= {XLEN{1'b0}};
            end
            wr_ptr_q   <= PTR_W'(0);
            rd_ptr_q   <= PTR_W'(0);
            fifo_cnt_q <= CNT_W'(0);
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= bus.sw_word_i;
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

`ifdef TRDB_SW_HEADER_EN
    // Header phase: the header leaves first, the payload pop closes the dump.
    always_comb begin
        hdr_pend_d = hdr_pend_q;
        seq_d      = seq_q;
        if (take_sw_s && !hdr_pend_q) begin
            hdr_pend_d = 1'b1;
            seq_d      = seq_q + 16'd1;
        end else if (pop_s) begin
            hdr_pend_d = 1'b0;
        end else begin
            hdr_pend_d = hdr_pend_q;
        end
    end

    // Header phase flag and dump sequence number.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_pend_q <= 1'b0;
            seq_q      <= 16'd0;
        end else begin
            hdr_pend_q <= hdr_pend_d;
            seq_q      <= seq_d;
        end
    end
`endif

    assign bus.trace_grant_o = take_trace_s;
    assign bus.word_o        = word_q;
    assign bus.word_src_o    = src_q;
    assign bus.word_valid_o  = valid_q;
    assign busy_o            = !fifo_empty_s || valid_q;
    assign sw_dropped_o      = dropped_q;
endmodule
